// File: rtl/yt_output_buf_pkg.sv
// Shared types, sizes and pack/unpack helpers for the y_t output tile buffer.
package yt_obuf_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TILE_SIZE = 4;
  localparam int unsigned WORD_W    = DATA_W * TILE_SIZE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} obuf_state_t;

  typedef logic signed [DATA_W-1:0] tile_t [TILE_SIZE-1:0];
  typedef logic [WORD_W-1:0]        word_t;

  // Element 0 lands in the least significant lane.
  function automatic word_t pack_tile(input tile_t t);
    word_t w;
    w = '0;
    for (int unsigned i = 0; i < TILE_SIZE; i++) begin
      w[DATA_W*i +: DATA_W] = t[i];
    end
    return w;
  endfunction

  // Inverse of pack_tile; each lane is reinterpreted as signed.
  function automatic void unpack_word(input word_t w, output tile_t t);
    for (int unsigned i = 0; i < TILE_SIZE; i++) begin
      t[i] = $signed(w[DATA_W*i +: DATA_W]);
    end
  endfunction

endpackage

// File: rtl/yt_output_buf_if.sv
// Tile write stream and read port of the y_t output buffer.
interface yt_output_buf_if #(
  parameter int unsigned ADDR_W = 6
);
  import yt_obuf_pkg::*;

  logic              in_valid;
  tile_t             in_vec;
  logic              in_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  tile_t             rd_vec;

  modport master (
    output in_valid, in_vec, rd_en, rd_addr,
    input  in_ready, rd_valid, rd_vec
  );

  modport slave (
    input  in_valid, in_vec, rd_en, rd_addr,
    output in_ready, rd_valid, rd_vec
  );

endinterface

// File: rtl/yt_output_buf_mem.sv
// 1W1R word store with a 2-stage registered read port (simple dual-port RAM).
// Optional macro YT_OBUF_RAW_BYPASS_EN: a same-cycle same-address read returns
// the word being written instead of the old contents.
module yt_obuf_mem
  import yt_obuf_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  word_t             wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output word_t             rd_data,
  output logic              rd_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Array is left uninitialised and unreset so it maps onto block RAM.
  word_t mem_sim [DEPTH];

  word_t stage1_q, stage1_d;
  word_t stage2_q;
  logic  v1_q, v2_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_sim[wr_addr] <= wr_data;
    end
  end

  // First read stage: capture on request, hold otherwise.
  always_comb begin
    stage1_d = stage1_q;
    if (rd_en) begin
`ifdef YT_OBUF_RAW_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr)) begin
        stage1_d = wr_data;
      end else begin
        stage1_d = mem_sim[rd_addr];
      end
`else
      stage1_d = mem_sim[rd_addr];
`endif
    end
  end

  // Read pipeline registers; stage2 only changes when a valid word reaches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage1_q;
      v1_q     <= rd_en;
      v2_q     <= v1_q;
    end
  end

  assign rd_data  = stage2_q;
  assign rd_valid = v2_q;

endmodule

// File: rtl/yt_output_buf.sv
// y_t output tile buffer: accepts 4x16 signed tiles on a valid/ready stream
// and writes them to a programmed run of consecutive (wrapping) addresses.
// Read port has 2-cycle latency and returns unpacked signed tiles.
// Optional macro YT_OBUF_RAW_BYPASS_EN enables write-first read forwarding.
module yt_output_buf
  import yt_obuf_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_tiles,
  yt_output_buf_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  obuf_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic              in_ready_q, in_ready_d;

  logic              xfer;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] wr_addr;
  word_t             wr_word;
  word_t             rd_word;
  tile_t             rd_tile;

  assign xfer    = bus.in_valid && in_ready_q;
  assign cnt_inc = wr_cnt_q + CNT_ONE;
  assign wr_addr = base_q + wr_cnt_q[ADDR_W-1:0];
  assign wr_word = pack_tile(bus.in_vec);

  // Next-state, run bookkeeping and registered-ready computation.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    wr_cnt_d = wr_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = (num_tiles > DEPTH_CNT) ? DEPTH_CNT : num_tiles;
          wr_cnt_d = '0;
          state_d  = (num_tiles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          wr_cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Ready follows the next state so it is high exactly while state is RUN.
    in_ready_d = (state_d == RUN);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      wr_cnt_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      wr_cnt_q   <= wr_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  yt_obuf_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (xfer),
    .wr_addr  (wr_addr),
    .wr_data  (wr_word),
    .rd_en    (bus.rd_en),
    .rd_addr  (bus.rd_addr),
    .rd_data  (rd_word),
    .rd_valid (bus.rd_valid)
  );

  // Split the read word back into signed elements.
  always_comb begin
    unpack_word(rd_word, rd_tile);
  end

  assign bus.rd_vec   = rd_tile;
  assign bus.in_ready = in_ready_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_yt_output_buf.sv
// Scoreboard bench for yt_output_buf: models memory contents and read latency.
module tb_yt_output_buf;
  import yt_obuf_pkg::*;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_tiles;
  logic          busy, done;
  logic [AW:0]   wr_cnt;

  yt_output_buf_if #(.ADDR_W(AW)) bus ();

  yt_output_buf #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_tiles (num_tiles),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .wr_cnt    (wr_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [63:0] model_mem [DEPTH];
  logic signed [15:0] tbl [3][4];

  typedef struct {
    logic [63:0] word;
    int          due;
  } rd_exp_t;
  rd_exp_t rdq[$];
  rd_exp_t mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tb_pack(input tile_t t);
    return {t[3], t[2], t[1], t[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Read-side scoreboard: every rd_valid must match the oldest pending request.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (rdq.size() == 0) begin
        check("rd_spurious", 64'(bus.rd_valid), 64'd0);
      end else begin
        mon_e = rdq.pop_front();
        check("rd_latency", 64'(cyc), 64'(mon_e.due));
        check("rd_data", tb_pack(bus.rd_vec), mon_e.word);
      end
    end else if (rdq.size() != 0 && rdq[0].due < cyc) begin
      check("rd_missing", 64'(cyc), 64'(rdq[0].due));
      void'(rdq.pop_front());
    end
  end

  task automatic rd(input logic [AW-1:0] a);
    rd_exp_t e;
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    e.word = model_mem[a];
    e.due  = cyc + 2;
    rdq.push_back(e);
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic mem_check();
    for (int i = 0; i < int'(DEPTH); i++) begin
      check($sformatf("mem[%0d]", i), dut.u_mem.mem_sim[i], model_mem[i]);
    end
  endtask

  task automatic run(input logic [AW-1:0] base, input int num, input bit toggle,
                     input bit use_tbl, input bit poke, input int coll_addr,
                     input int abort_after);
    int eff;
    int sent;
    int k;
    logic [63:0] w;
    logic [AW-1:0] a;
    rd_exp_t e;
    eff  = (num > int'(DEPTH)) ? int'(DEPTH) : num;
    sent = 0;
    k    = 0;
    start     = 1'b1;
    base_addr = base;
    num_tiles = 7'(num);
    step();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("cnt_cleared", 64'(wr_cnt), 64'd0);
    if (eff == 0) begin
      check("done_empty", 64'(done), 64'd1);
      check("rdy_empty", 64'(bus.in_ready), 64'd0);
      step();
      check("done_empty_end", 64'(done), 64'd0);
      check("busy_empty_end", 64'(busy), 64'd0);
      return;
    end
    while (sent < eff && k < 400) begin
      check("in_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = toggle ? (k % 2 == 0) : 1'b1;
      for (int i = 0; i < 4; i++) begin
        bus.in_vec[i] = use_tbl ? tbl[sent][i] : 16'($urandom);
      end
      a = base + AW'(sent);
      w = tb_pack(bus.in_vec);
      if (poke && sent == 1) begin
        start     = 1'b1;
        base_addr = base + 6'd30;
        num_tiles = 7'd2;
      end
      if (bus.in_valid && coll_addr == int'(a)) begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
`ifdef YT_OBUF_RAW_BYPASS_EN
        e.word = w;
`else
        e.word = model_mem[a];
`endif
        e.due = cyc + 2;
        rdq.push_back(e);
      end
      step();
      start     = 1'b0;
      bus.rd_en = 1'b0;
      if (bus.in_valid) begin
        model_mem[a] = w;
        sent++;
      end
      k++;
      check("wr_cnt", 64'(wr_cnt), 64'(sent));
      if (abort_after >= 0 && sent == abort_after) begin
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(bus.in_ready), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_cnt", 64'(wr_cnt), 64'd0);
        return;
      end
    end
    if (sent != eff) check("run_timeout", 64'(sent), 64'(eff));
    bus.in_valid = 1'b0;
    check("done_after_last", 64'(done), 64'd1);
    check("ready_drop", 64'(bus.in_ready), 64'd0);
    check("busy_in_done", 64'(busy), 64'd1);
    step();
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("cnt_final", 64'(wr_cnt), 64'(eff));
  endtask

  initial begin
    tbl = '{'{16'sd1, -16'sd2, 16'sd3, -16'sd4},
            '{16'sd5, 16'sd6, 16'sd7, 16'sd8},
            '{16'sd9, 16'sd10, 16'sd11, 16'sd12}};
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    num_tiles    = '0;
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    for (int i = 0; i < 4; i++) bus.in_vec[i] = '0;

    // Reset state.
    repeat (3) step();
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cnt", 64'(wr_cnt), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_vec", tb_pack(bus.rd_vec), 64'd0);

    // Start while reset is held must be ignored.
    start     = 1'b1;
    base_addr = 6'd4;
    num_tiles = 7'd3;
    step();
    start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();
    check("rst_start_idle", 64'(busy), 64'd0);
    check("rst_start_ready", 64'(bus.in_ready), 64'd0);

    // Oversized run clamps to full depth and fills the whole buffer.
    run(6'd0, 70, 1'b0, 1'b0, 1'b0, -1, -1);
    mem_check();

    // Basic run with fixed tiles.
    run(6'd4, 3, 1'b0, 1'b1, 1'b0, -1, -1);
    check("mem4_const", dut.u_mem.mem_sim[4], 64'hFFFC_0003_FFFE_0001);
    mem_check();

    // Readback of addr 5 and hold of rd_vec afterwards.
    rd(6'd5);
    repeat (4) step();
    check("rd_vec_hold", tb_pack(bus.rd_vec), 64'h0008_0007_0006_0005);

    // Wrap-around with bubbles.
    run(6'd62, 4, 1'b1, 1'b0, 1'b0, -1, -1);
    mem_check();

    // Empty run.
    run(6'd10, 0, 1'b0, 1'b0, 1'b0, -1, -1);

    // Start pulse during RUN is ignored.
    run(6'd40, 4, 1'b0, 1'b0, 1'b1, -1, -1);
    mem_check();

    // Same-cycle read and write of address 7.
    run(6'd6, 3, 1'b0, 1'b0, 1'b0, 7, -1);
    repeat (3) step();
    mem_check();

    // Reset mid-run after 2 of 5 tiles; written words persist.
    run(6'd20, 5, 1'b0, 1'b0, 1'b0, -1, 2);
    rd(6'd20);
    rd(6'd21);
    mem_check();

    // Back-to-back random reads.
    for (int n = 0; n < 12; n++) rd(AW'($urandom_range(0, DEPTH - 1)));

    for (int n = 0; n < 10 && rdq.size() != 0; n++) step();
    if (rdq.size() != 0) check("rdq_drain", 64'(rdq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
